// File: rtl/ex_fwd_unit_if.sv
// ---------------------------------------------------------------------------
// ex_fwd_unit_if
//   Issue channel between decode and the EX forwarding unit.
//   Decode (master) presents one instruction per cycle together with its
//   regfile read data. The EX unit (slave) answers with issue_ready, which
//   drops while a load-use hazard holds the EX register.
//
//   Signals:
//     issue_valid    decode presents an instruction
//     issue_ready    EX can accept this cycle
//     issue_rs1/rs2  source register indices
//     issue_rd       destination index
//     issue_we       instruction writes rd
//     issue_is_load  result comes from memory
//     issue_rs1_val  regfile data for rs1
//     issue_rs2_val  regfile data for rs2
//     issue_pc       instruction pc
//     issue_imm      immediate
//     issue_asel_pc  op_a takes pc instead of rs1
//     issue_bsel_imm op_b takes imm instead of rs2
// ---------------------------------------------------------------------------
interface ex_fwd_unit_if #(
   parameter int XLEN = 32
);
   logic            issue_valid;
   logic            issue_ready;
   logic [4:0]      issue_rs1;
   logic [4:0]      issue_rs2;
   logic [4:0]      issue_rd;
   logic            issue_we;
   logic            issue_is_load;
   logic [XLEN-1:0] issue_rs1_val;
   logic [XLEN-1:0] issue_rs2_val;
   logic [XLEN-1:0] issue_pc;
   logic [XLEN-1:0] issue_imm;
   logic            issue_asel_pc;
   logic            issue_bsel_imm;

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_we,
             issue_is_load, issue_rs1_val, issue_rs2_val, issue_pc,
             issue_imm, issue_asel_pc, issue_bsel_imm,
      input  issue_ready
   );

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_we,
             issue_is_load, issue_rs1_val, issue_rs2_val, issue_pc,
             issue_imm, issue_asel_pc, issue_bsel_imm,
      output issue_ready
   );
endinterface

// File: rtl/ex_fwd_unit.sv
// ---------------------------------------------------------------------------
// ex_fwd_unit
//   ID/EX operand register plus an in-flight destination tracker covering
//   NUM_STAGES stages downstream of EX. Resolves RAW hazards for the
//   instruction sitting in EX: the youngest matching tracker entry supplies
//   the operand from fwd_data, unless it is a load whose data is not yet
//   available (entry index < LOAD_LAT), in which case EX stalls.
//
//   Parameters:
//     XLEN        datapath width
//     NUM_STAGES  tracker depth (entry 0 = stage right after EX)
//     LOAD_LAT    first tracker entry where load data is valid in fwd_data
//
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     issue       decode issue channel (ex_fwd_unit_if.slave)
//     flush       kill the EX instruction (branch redirect)
//     fwd_data    result of tracker entry k at [k*XLEN +: XLEN]
//     ex_valid    op_a/op_b valid and the EX instruction advances
//     ex_rd       destination of the EX instruction
//     op_a, op_b  final ALU operands
//     stall       load-use hazard in EX
//
//   Optional build macro FWD_STATS_EN adds:
//     stat_clear         clear both counters (wins over increment)
//     stat_stall_cycles  cycles with stall=1, saturating
//     stat_fwd_count     operands taken from fwd_data while ex_valid=1,
//                        saturating
// ---------------------------------------------------------------------------
module ex_fwd_unit #(
   parameter int XLEN       = 32,
   parameter int NUM_STAGES = 2,
   parameter int LOAD_LAT   = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   ex_fwd_unit_if.slave               issue,
   input  logic                       flush,
   input  logic [NUM_STAGES*XLEN-1:0] fwd_data,
   output logic                       ex_valid,
   output logic [4:0]                 ex_rd,
   output logic [XLEN-1:0]            op_a,
   output logic [XLEN-1:0]            op_b,
   output logic                       stall
`ifdef FWD_STATS_EN
   ,
   input  logic                       stat_clear,
   output logic [31:0]                stat_stall_cycles,
   output logic [31:0]                stat_fwd_count
`endif
);

   typedef struct packed {
      logic            valid;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            we;
      logic            is_load;
      logic            asel_pc;
      logic            bsel_imm;
      logic [XLEN-1:0] rs1_val;
      logic [XLEN-1:0] rs2_val;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
   } ex_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       we;
      logic       is_load;
   } trk_t;

   ex_t  ex_reg;
   ex_t  ex_next;
   ex_t  issue_word;
   trk_t trk_reg [NUM_STAGES];
   trk_t trk_head;

   // Per-source views: index 0 is rs1/op_a, index 1 is rs2/op_b.
   logic [4:0]      src_idx [2];
   logic [XLEN-1:0] src_val [2];
   logic [XLEN-1:0] src_res [2];
   logic [1:0]      src_used;
   logic [1:0]      src_haz;
   logic [1:0]      src_fwd;

   assign issue_word = {1'b1, issue.issue_rs1, issue.issue_rs2, issue.issue_rd,
                        issue.issue_we, issue.issue_is_load,
                        issue.issue_asel_pc, issue.issue_bsel_imm,
                        issue.issue_rs1_val, issue.issue_rs2_val,
                        issue.issue_pc, issue.issue_imm};

   assign src_idx[0]  = ex_reg.rs1;
   assign src_idx[1]  = ex_reg.rs2;
   assign src_val[0]  = ex_reg.rs1_val;
   assign src_val[1]  = ex_reg.rs2_val;
   // x0 is never forwarded, and a source replaced by pc/imm never hazards.
   assign src_used[0] = !ex_reg.asel_pc  && (ex_reg.rs1 != 5'd0);
   assign src_used[1] = !ex_reg.bsel_imm && (ex_reg.rs2 != 5'd0);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         logic            hit;
         logic            late;
         logic [XLEN-1:0] fwd_val;

         // Scan oldest to youngest so the lowest matching k is the one
         // left standing (youngest producer wins).
         always_comb begin
            hit     = 1'b0;
            late    = 1'b0;
            fwd_val = src_val[gi];
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
               if (trk_reg[k].valid && trk_reg[k].we &&
                   (trk_reg[k].rd != 5'd0) && (trk_reg[k].rd == src_idx[gi])) begin
                  hit     = 1'b1;
                  late    = trk_reg[k].is_load && (k < LOAD_LAT);
                  fwd_val = fwd_data[k*XLEN +: XLEN];
               end
            end
         end

         assign src_haz[gi] = src_used[gi] & hit & late;
         assign src_fwd[gi] = src_used[gi] & hit & ~late;
         assign src_res[gi] = src_fwd[gi] ? fwd_val : src_val[gi];
      end
   endgenerate

   assign stall             = ex_reg.valid & (|src_haz);
   assign issue.issue_ready = ~stall;
   assign ex_valid          = ex_reg.valid & ~stall & ~flush;
   assign ex_rd             = ex_reg.rd;
   assign op_a              = ex_reg.asel_pc  ? ex_reg.pc  : src_res[0];
   assign op_b              = ex_reg.bsel_imm ? ex_reg.imm : src_res[1];

   // Stalled instructions hold EX; a flush turns EX into a bubble even then.
   // An accepted issue on a flush cycle still enters EX (it is younger than
   // the killed instruction).
   always_comb begin
      ex_next = ex_reg;
      if (!stall) begin
         ex_next = issue.issue_valid ? issue_word : '0;
      end else if (flush) begin
         ex_next = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_reg <= '0;
      end else begin
         ex_reg <= ex_next;
      end
   end

   // Only an instruction that actually leaves EX enters the tracker; stalls
   // and flushes inject a bubble while older entries keep moving.
   assign trk_head = ex_valid ? {1'b1, ex_reg.rd, ex_reg.we, ex_reg.is_load} : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            trk_reg[k] <= '0;
         end
      end else begin
         trk_reg[0] <= trk_head;
         for (int k = 1; k < NUM_STAGES; k++) begin
            trk_reg[k] <= trk_reg[k-1];
         end
      end
   end

`ifdef FWD_STATS_EN
   logic [31:0] stall_cnt_reg;
   logic [31:0] fwd_cnt_reg;
   logic [1:0]  fwd_inc;
   logic [32:0] fwd_sum;

   assign fwd_inc = ex_valid ? ({1'b0, src_fwd[0]} + {1'b0, src_fwd[1]}) : 2'd0;
   assign fwd_sum = {1'b0, fwd_cnt_reg} + {31'd0, fwd_inc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
         fwd_cnt_reg   <= '0;
      end else if (stat_clear) begin
         stall_cnt_reg <= '0;
         fwd_cnt_reg   <= '0;
      end else begin
         if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         end
         fwd_cnt_reg <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
      end
   end

   assign stat_stall_cycles = stall_cnt_reg;
   assign stat_fwd_count    = fwd_cnt_reg;
`endif

endmodule

// File: tb/tb_ex_fwd_unit.sv
module tb_ex_fwd_unit;
   localparam int XLEN = 32;
   localparam int NS   = 2;
   localparam int LL   = 1;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic [NS*XLEN-1:0] fwd_data;
   logic             ex_valid;
   logic [4:0]       ex_rd;
   logic [XLEN-1:0]  op_a;
   logic [XLEN-1:0]  op_b;
   logic             stall;
`ifdef FWD_STATS_EN
   logic             stat_clear;
   logic [31:0]      stat_stall_cycles;
   logic [31:0]      stat_fwd_count;
`endif

   int checks   = 0;
   int failures = 0;

   ex_fwd_unit_if #(.XLEN(XLEN)) bus ();

   ex_fwd_unit #(.XLEN(XLEN), .NUM_STAGES(NS), .LOAD_LAT(LL)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .issue    (bus),
      .flush    (flush),
      .fwd_data (fwd_data),
      .ex_valid (ex_valid),
      .ex_rd    (ex_rd),
      .op_a     (op_a),
      .op_b     (op_b),
      .stall    (stall)
`ifdef FWD_STATS_EN
      ,
      .stat_clear        (stat_clear),
      .stat_stall_cycles (stat_stall_cycles),
      .stat_fwd_count    (stat_fwd_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: the instruction in EX plus the list of instructions
   // that have left EX, youngest first.
   // ------------------------------------------------------------------
   typedef struct {
      bit          v;
      logic [4:0]  rs1, rs2, rd;
      bit          we, ld, asel, bsel;
      logic [31:0] r1v, r2v, pc, imm;
   } minst_t;

   minst_t     m_ex;
   bit         h_v  [NS];
   logic [4:0] h_rd [NS];
   bit         h_we [NS];
   bit         h_ld [NS];

   function automatic minst_t empty_inst();
      minst_t e;
      e.v = 0; e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.we = 0; e.ld = 0;
      e.asel = 0; e.bsel = 0; e.r1v = 0; e.r2v = 0; e.pc = 0; e.imm = 0;
      return e;
   endfunction

   // Youngest in-flight writer of idx decides; loads younger than LL are not ready.
   function automatic void resolve(input logic [4:0] idx, input logic [31:0] regval,
                                   output bit haz, output logic [31:0] val);
      haz = 0;
      val = regval;
      if (idx != 5'd0) begin
         for (int k = 0; k < NS; k++) begin
            if (h_v[k] && h_we[k] && h_rd[k] == idx) begin
               if (h_ld[k] && k < LL) haz = 1;
               else val = fwd_data[k*XLEN +: XLEN];
               break;
            end
         end
      end
   endfunction

   function automatic bit model_stall();
      bit ha, hb;
      logic [31:0] va, vb;
      resolve(m_ex.rs1, m_ex.r1v, ha, va);
      resolve(m_ex.rs2, m_ex.r2v, hb, vb);
      return m_ex.v && ((!m_ex.asel && ha) || (!m_ex.bsel && hb));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ex = empty_inst();
         for (int k = 0; k < NS; k++) begin
            h_v[k] = 0; h_rd[k] = 0; h_we[k] = 0; h_ld[k] = 0;
         end
      end else begin
         bit st, adv;
         st  = model_stall();
         adv = m_ex.v && !st && !flush;
         for (int k = NS - 1; k > 0; k--) begin
            h_v[k] = h_v[k-1]; h_rd[k] = h_rd[k-1]; h_we[k] = h_we[k-1]; h_ld[k] = h_ld[k-1];
         end
         h_v[0]  = adv;
         h_rd[0] = adv ? m_ex.rd : 5'd0;
         h_we[0] = adv && m_ex.we;
         h_ld[0] = adv && m_ex.ld;
         if (!st) begin
            if (bus.issue_valid) begin
               m_ex.v    = 1;
               m_ex.rs1  = bus.issue_rs1;     m_ex.rs2  = bus.issue_rs2;
               m_ex.rd   = bus.issue_rd;      m_ex.we   = bus.issue_we;
               m_ex.ld   = bus.issue_is_load; m_ex.asel = bus.issue_asel_pc;
               m_ex.bsel = bus.issue_bsel_imm;
               m_ex.r1v  = bus.issue_rs1_val; m_ex.r2v  = bus.issue_rs2_val;
               m_ex.pc   = bus.issue_pc;      m_ex.imm  = bus.issue_imm;
            end else begin
               m_ex = empty_inst();
            end
         end else if (flush) begin
            m_ex = empty_inst();
         end
      end
   end

   // Compare process: every falling edge, DUT against model.
   always @(negedge clk) begin
      bit ha, hb, st, ev;
      logic [31:0] va, vb;
      resolve(m_ex.rs1, m_ex.r1v, ha, va);
      resolve(m_ex.rs2, m_ex.r2v, hb, vb);
      st = m_ex.v && ((!m_ex.asel && ha) || (!m_ex.bsel && hb));
      ev = m_ex.v && !st && !flush;
      chk("m_ex_valid", {31'd0, ex_valid}, {31'd0, ev});
      chk("m_stall", {31'd0, stall}, {31'd0, st});
      chk("m_issue_ready", {31'd0, bus.issue_ready}, {31'd0, !st});
      chk("m_ex_rd", {27'd0, ex_rd}, {27'd0, m_ex.rd});
      if (ev) begin
         chk("m_op_a", op_a, m_ex.asel ? m_ex.pc : va);
         chk("m_op_b", op_b, m_ex.bsel ? m_ex.imm : vb);
      end
      $display("t=%0t rst_n=%0b ex_valid=%0b stall=%0b ready=%0b ex_rd=%0d op_a=%h op_b=%h",
               $time, rst_n, ex_valid, stall, bus.issue_ready, ex_rd, op_a, op_b);
   end

   // ------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after the falling edge.
   // ------------------------------------------------------------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input bit we, input bit ld, input bit asel, input bit bsel,
                        input logic [31:0] r1v, input logic [31:0] r2v,
                        input logic [31:0] pc, input logic [31:0] imm);
      bus.issue_valid    = 1'b1;
      bus.issue_rs1      = rs1;  bus.issue_rs2     = rs2;
      bus.issue_rd       = rd;   bus.issue_we      = we;
      bus.issue_is_load  = ld;   bus.issue_asel_pc = asel;
      bus.issue_bsel_imm = bsel;
      bus.issue_rs1_val  = r1v;  bus.issue_rs2_val = r2v;
      bus.issue_pc       = pc;   bus.issue_imm     = imm;
   endtask

   task automatic idle();
      bus.issue_valid = 1'b0;
   endtask

   task automatic set_fwd(input logic [31:0] f0, input logic [31:0] f1);
      fwd_data = {f1, f0};
   endtask

   initial begin
      rst_n    = 1'b0;
      flush    = 1'b0;
      fwd_data = '0;
`ifdef FWD_STATS_EN
      stat_clear = 1'b0;
`endif
      // addi x5, x1, 3 held on the bus throughout reset
      drive(5'd1, 5'd0, 5'd5, 1, 0, 0, 1, 32'h1, 32'h0, 32'h1000, 32'h3);
      step(); step(); step();
      chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_op_a", op_a, 32'd0);
      chk("rst_op_b", op_b, 32'd0);
      chk("rst_ready", {31'd0, bus.issue_ready}, 32'd1);
      chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_no_capture_yet", {31'd0, ex_valid}, 32'd0);
      step();
      chk("first_capture_valid", {31'd0, ex_valid}, 32'd1);
      chk("first_capture_rd", {27'd0, ex_rd}, 32'd5);
      chk("first_capture_imm", op_b, 32'd3);

      // add x6, x1, x2 : independent
      drive(5'd1, 5'd2, 5'd6, 1, 0, 0, 0, 32'd7, 32'd9, 32'h1004, 32'h0);
      step();
      chk("indep_op_a", op_a, 32'd7);
      chk("indep_op_b", op_b, 32'd9);
      chk("indep_stall", {31'd0, stall}, 32'd0);

      // two x5 writers, then add x7, x5, x5
      drive(5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 32'd1, 32'd2, 32'h1008, 32'h0);
      step();
      drive(5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 32'd1, 32'd2, 32'h100C, 32'h0);
      step();
      drive(5'd5, 5'd5, 5'd7, 1, 0, 0, 0, 32'h55, 32'h55, 32'h1010, 32'h0);
      set_fwd(32'h10, 32'h20);
      step();
      chk("raw_youngest_a", op_a, 32'h10);
      chk("raw_youngest_b", op_b, 32'h10);

      // lw x5 then add x6, x5, x0
      drive(5'd1, 5'd0, 5'd5, 1, 1, 0, 1, 32'h0, 32'h0, 32'h1014, 32'h40);
      step();
      drive(5'd5, 5'd0, 5'd6, 1, 0, 0, 0, 32'h55, 32'h0, 32'h1018, 32'h0);
      step();
      chk("lu_stall", {31'd0, stall}, 32'd1);
      chk("lu_ready", {31'd0, bus.issue_ready}, 32'd0);
      chk("lu_ex_valid", {31'd0, ex_valid}, 32'd0);
      idle();
      set_fwd(32'h0, 32'hDEAD);
      step();
      chk("lu_release_stall", {31'd0, stall}, 32'd0);
      chk("lu_op_a", op_a, 32'hDEAD);
      chk("lu_op_b", op_b, 32'h0);
      chk("lu_ex_valid2", {31'd0, ex_valid}, 32'd1);
      step();

      // write to x0 in entry0, consumer reads x0
      drive(5'd1, 5'd2, 5'd0, 1, 0, 0, 0, 32'd1, 32'd2, 32'h1020, 32'h0);
      step();
      drive(5'd0, 5'd0, 5'd11, 1, 0, 0, 0, 32'd0, 32'd0, 32'h1024, 32'h0);
      set_fwd(32'hFFFF, 32'hFFFF);
      step();
      chk("x0_op_a", op_a, 32'd0);
      chk("x0_op_b", op_b, 32'd0);

      // lw x12 then a pc/imm consumer naming x12 as rs1
      drive(5'd1, 5'd0, 5'd12, 1, 1, 0, 1, 32'h0, 32'h0, 32'h1028, 32'h8);
      step();
      drive(5'd12, 5'd0, 5'd16, 1, 0, 1, 1, 32'h77, 32'h0, 32'h100, 32'h4);
`ifdef FWD_STATS_EN
      stat_clear = 1'b1;
`endif
      step();
`ifdef FWD_STATS_EN
      stat_clear = 1'b0;
`endif
      chk("asel_op_a", op_a, 32'h100);
      chk("asel_op_b", op_b, 32'h4);
      chk("asel_stall", {31'd0, stall}, 32'd0);

      // flush during a load-use stall
      drive(5'd1, 5'd0, 5'd13, 1, 1, 0, 1, 32'h0, 32'h0, 32'h1030, 32'h0);
      step();
      drive(5'd13, 5'd0, 5'd14, 1, 0, 0, 0, 32'h0, 32'h0, 32'h1034, 32'h0);
      step();
      chk("fl_pre_stall", {31'd0, stall}, 32'd1);
      flush = 1'b1;
      drive(5'd1, 5'd2, 5'd15, 1, 0, 0, 0, 32'h15, 32'h16, 32'h1038, 32'h0);
      step();
      flush = 1'b0;
      chk("fl_bubble_valid", {31'd0, ex_valid}, 32'd0);
      chk("fl_bubble_stall", {31'd0, stall}, 32'd0);
      chk("fl_ready", {31'd0, bus.issue_ready}, 32'd1);
      step();
      chk("fl_next_valid", {31'd0, ex_valid}, 32'd1);
      chk("fl_next_rd", {27'd0, ex_rd}, 32'd15);
      chk("fl_next_op_a", op_a, 32'h15);
      chk("fl_next_op_b", op_b, 32'h16);
`ifdef FWD_STATS_EN
      chk("stat_stall_cycles", stat_stall_cycles, 32'd1);
`endif
      idle();
      step(); step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
